// File: rtl/prm_scan_pkg.sv
// prm_scan_pkg: shared definitions for the PRM obstacle scan block.
// Holds the scan FSM state type, the obstacle code width and default sizes.
package prm_scan_pkg;

    // Obstacle voxel code width: one bit per checker input A..O
    localparam int OBS_CODE_W = 15;

    // Default number of roadmap edges served by the checker bank
    localparam int EDGE_NUM_DEF = 32;

    // Default width of the obstacle counter
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/prm_mask_accum.sv
// prm_mask_accum: OR-accumulates edge masks into a blocked-edge vector.
// Clear has priority over enable so a new scan always starts from zero.
module prm_mask_accum #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] vector
);

    // Sticky OR of every enabled mask since the last clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vector <= '0;
        end else if (clear) begin
            vector <= '0;
        end else if (enable) begin
            vector <= vector | mask;
        end
    end

endmodule

// File: rtl/prm_oblgc_scan.sv
// prm_oblgc_scan: streams obstacle voxel codes to an external edge-checker
// bank and ORs the returned edge masks into a blocked-edge result vector.
// Optional build macro PRM_SCAN_CNT_EN adds a saturating obstacle counter;
// without it obs_count is tied to zero and no counter register exists.
module prm_oblgc_scan
    import prm_scan_pkg::*;
#(
    parameter int EDGE_NUM = EDGE_NUM_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  obs_valid,
    output logic                  obs_ready,
    input  logic [OBS_CODE_W-1:0] obs_code,
    input  logic                  obs_last,
    output logic [OBS_CODE_W-1:0] chk_code,
    input  logic [EDGE_NUM-1:0]   chk_mask,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [EDGE_NUM-1:0]   res_blocked,
    output logic [CNT_W-1:0]      obs_count
);

    scan_state_t state;
    scan_state_t state_next;
    logic        chk_vld;
    logic        obs_hs;
    logic        scan_clear;

    assign obs_hs = obs_valid & obs_ready;

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; DRAIN waits until the final mask
    // has landed in the accumulator before the result is offered
    always_comb begin
        state_next = state;
        scan_clear = 1'b0;
        obs_ready  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SCAN;
                    scan_clear = 1'b1;
                end
            end
            ST_SCAN: begin
                obs_ready = 1'b1;
                if (obs_valid && obs_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!chk_vld) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register each accepted code toward the checker bank; chk_vld marks
    // the single cycle in which the bank's mask belongs to a fresh code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_code <= '0;
            chk_vld  <= 1'b0;
        end else begin
            chk_vld <= obs_hs;
            if (obs_hs) begin
                chk_code <= obs_code;
            end
        end
    end

    prm_mask_accum #(
        .WIDTH (EDGE_NUM)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (scan_clear),
        .enable (chk_vld),
        .mask   (chk_mask),
        .vector (res_blocked)
    );

`ifdef PRM_SCAN_CNT_EN
    logic [CNT_W-1:0] count_q;

    // Saturating count of obstacles accepted in the current scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (scan_clear) begin
            count_q <= '0;
        end else if (obs_hs && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign obs_count = count_q;
`else
    assign obs_count = '0;
`endif

endmodule
